// File: rtl/arith_seq_pkg.sv
// Shared types for sequenced arithmetic cells: controller state encoding and
// the word-index width helper.
package arith_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // A single-word sequencer still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/n_bit_adder.sv
// N-bit ripple-carry adder slice, time-shared by the wide-add sequencer.
module n_bit_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[N];

endmodule

// File: rtl/wide_add_sequencer.sv
// (N*WORDS)-bit adder built from one N-bit slice, stepped least-significant
// word first with the inter-word carry held in a register.
module wide_add_sequencer
  import arith_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] in_a,
  input  logic [N*WORDS-1:0] in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] out_sum,
  output logic               out_cout,
  output logic               busy
);

  localparam int W  = N * WORDS;
  localparam int KW = idx_width(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  seq_state_e    state_q, state_d;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          carry_q, cout_q;
  logic [KW-1:0] k_q;

  logic [N-1:0]  add_a, add_b, add_sum;
  logic          add_cout;

  assign add_a = a_q[int'(k_q) * N +: N];
  assign add_b = b_q[int'(k_q) * N +: N];

  n_bit_adder #(.N(N)) u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)       state_d = RUN;
      RUN:     if (k_q == K_LAST)  state_d = DONE;
      DONE:    if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands latch only on acceptance; result words fill in as k advances and
  // stay untouched through DONE, so backpressure never disturbs them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            k_q     <= '0;
          end
        end
        RUN: begin
          sum_q[int'(k_q) * N +: N] <= add_sum;
          carry_q                   <= add_cout;
          if (k_q == K_LAST) cout_q <= add_cout;
          else               k_q    <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule
